// File: rtl/dac_channel_scheduler.sv
// Round-robin scheduler that feeds per-channel DAC codes and control words to a serial
// DAC driver and generates the registered, active-low LDAC load strobe.
module dac_channel_scheduler #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned LDAC_PULSE = 4,
  parameter int unsigned AUTO_LDAC  = 1
) (
  input  logic        clkin,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [2:0]  wr_ch,
  input  logic [9:0]  wr_data,
  input  logic        cfg_valid,
  input  logic [15:0] cfg_word,
  output logic        cfg_ready,
  input  logic        ldac_req,
  output logic [15:0] m_tdata,
  output logic [2:0]  m_tuser,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        ldac_b,
  output logic [7:0]  pending,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StWaitDone, StLdac} state_e;

  state_e      r_state, w_state_d;
  logic [9:0]  r_val [8];
  logic [7:0]  r_pend, w_pend_d;
  logic        r_cfg_full;
  logic [15:0] r_cfg_word;
  logic [2:0]  r_rr_ptr;
  logic [15:0] r_tdata;
  logic [2:0]  r_tuser;
  logic        r_ldac_b;
  logic [3:0]  r_ldac_cnt;
  logic [2:0]  r_busy_cnt;
  logic        r_ldac_req;
  logic        r_batch_ch;

  logic        w_wr_ok, w_cfg_acc, w_work, w_sel_new, w_sel_found, w_ldac_any;
  logic [2:0]  w_sel_ch;
  logic [3:0]  w_idx;

  assign w_wr_ok    = wr_en && ({1'b0, wr_ch} < 4'(NUM_CH));
  assign w_cfg_acc  = cfg_valid && !r_cfg_full && cfg_word[15];
  assign w_work     = r_cfg_full || (|r_pend);
  assign w_ldac_any = r_ldac_req || ldac_req;

  // First pending channel at or after the round-robin pointer, wrapping at NUM_CH.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_ch    = '0;
    w_idx       = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_idx = {1'b0, r_rr_ptr} + 4'(i);
      if (w_idx >= 4'(NUM_CH)) w_idx = w_idx - 4'(NUM_CH);
      if (!w_sel_found && r_pend[w_idx[2:0]]) begin
        w_sel_found = 1'b1;
        w_sel_ch    = w_idx[2:0];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_sel_new = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_ldac_any) begin
          w_state_d = StLdac;
        end else if (w_work && m_tready) begin
          w_state_d = StIssue;
          w_sel_new = 1'b1;
        end
      end
      StIssue: w_state_d = StWaitBusy;
      StWaitBusy: begin
        // A driver that never drops ready missed the word; send it again.
        if (!m_tready) w_state_d = StWaitDone;
        else if (r_busy_cnt == 3'd7) w_state_d = StIssue;
      end
      StWaitDone: begin
        if (m_tready) begin
          if (w_work) begin
            w_state_d = StIssue;
            w_sel_new = 1'b1;
          end else if (w_ldac_any || ((AUTO_LDAC != 0) && r_batch_ch)) begin
            w_state_d = StLdac;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StLdac: if (r_ldac_cnt == 4'(LDAC_PULSE - 1)) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // A write landing on the cycle its channel is taken wins, so the channel stays pending.
  always_comb begin
    w_pend_d = r_pend;
    if (w_sel_new && !r_cfg_full) w_pend_d[w_sel_ch] = 1'b0;
    if (w_wr_ok) w_pend_d[wr_ch] = 1'b1;
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StIdle;
      for (int i = 0; i < 8; i++) r_val[i] <= '0;
      r_pend     <= '0;
      r_cfg_full <= 1'b0;
      r_cfg_word <= '0;
      r_rr_ptr   <= '0;
      r_tdata    <= '0;
      r_tuser    <= '0;
      r_ldac_b   <= 1'b1;
      r_ldac_cnt <= '0;
      r_busy_cnt <= '0;
      r_ldac_req <= 1'b0;
      r_batch_ch <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pend  <= w_pend_d;
      if (w_wr_ok) r_val[wr_ch] <= wr_data;

      if (w_sel_new && r_cfg_full) begin
        r_cfg_full <= 1'b0;
      end else if (w_cfg_acc) begin
        r_cfg_full <= 1'b1;
        r_cfg_word <= cfg_word;
      end

      if (w_sel_new) begin
        if (r_cfg_full) begin
          r_tdata <= r_cfg_word;
          r_tuser <= '0;
        end else begin
          r_tdata    <= {6'b0, r_val[w_sel_ch]};
          r_tuser    <= w_sel_ch;
          r_rr_ptr   <= (w_sel_ch == 3'(NUM_CH - 1)) ? 3'd0 : w_sel_ch + 3'd1;
          r_batch_ch <= 1'b1;
        end
      end else if (w_state_d == StIdle || w_state_d == StLdac) begin
        r_batch_ch <= 1'b0;
      end

      r_busy_cnt <= (r_state == StWaitBusy) ? r_busy_cnt + 3'd1 : 3'd0;
      r_ldac_cnt <= (r_state == StLdac) ? r_ldac_cnt + 4'd1 : 4'd0;
      r_ldac_b   <= (w_state_d != StLdac);

      if (w_state_d == StLdac && r_state != StLdac) r_ldac_req <= 1'b0;
      else if (ldac_req) r_ldac_req <= 1'b1;
    end
  end

  assign cfg_ready = !r_cfg_full;
  assign m_tdata   = r_tdata;
  assign m_tuser   = r_tuser;
  assign m_tvalid  = (r_state == StIssue);
  assign ldac_b    = r_ldac_b;
  assign pending   = r_pend;
  assign busy      = (r_state != StIdle);

endmodule
